// File: rtl/dualmem_param.sv
// Parametrised single-clock true dual-port RAM with per-lane write enables,
// write-first same-address forwarding, optional output register and zero-fill after reset.
module dualmem_param #(
  parameter int DATA_WIDTH    = 1260,
  parameter int ADDR_WIDTH    = 9,
  parameter int LANE_WIDTH    = 36,
  parameter int OUT_REG       = 0,
  parameter int INIT_ON_RESET = 1,
  localparam int LANES        = (DATA_WIDTH + LANE_WIDTH - 1) / LANE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  input  logic                  a_req,
  output logic                  a_gnt,
  input  logic                  a_we,
  input  logic [LANES-1:0]      a_be,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  output logic                  b_gnt,
  input  logic                  b_we,
  input  logic [LANES-1:0]      b_be,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  collision
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] S_INIT  = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;
  localparam logic [0:0] S_RST   = (INIT_ON_RESET != 0) ? S_INIT : S_READY;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  ready;
  logic                  init_we;
  logic                  a_wr, a_rd, b_wr, b_rd;
  logic                  same_addr;
  logic                  a_rv1, b_rv1;
  logic [DATA_WIDTH-1:0] a_q1, b_q1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RST;
      cnt   <= '0;
    end else if (state == S_INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == {ADDR_WIDTH{1'b1}}) state <= S_READY;
    end
  end

  assign init_busy = (state == S_INIT);
  assign init_we   = (state == S_INIT);
  // Grants are withheld while reset is asserted even when the FSM rests in READY.
  assign ready     = (state == S_READY) & ~rst;

  assign a_gnt     = a_req & ready;
  assign b_gnt     = b_req & ready;
  assign a_wr      = a_gnt & a_we;
  assign a_rd      = a_gnt & ~a_we;
  assign b_wr      = b_gnt & b_we;
  assign b_rd      = b_gnt & ~b_we;
  assign same_addr = (a_addr == b_addr);

  // Storage is split per lane so each lane is an independent RAM with its own write enable.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int LO = i * LANE_WIDTH;
    localparam int W  = (LO + LANE_WIDTH > DATA_WIDTH) ? (DATA_WIDTH - LO) : LANE_WIDTH;

    logic [W-1:0] lane_mem [DEPTH];
    logic [W-1:0] a_q, b_q;
    logic         a_lwe, b_lwe;

    // Port A owns a lane when both ports write it at the same address.
    assign a_lwe = a_wr & a_be[i];
    assign b_lwe = b_wr & b_be[i] & ~(a_lwe & same_addr);

    // NOTE: the array and its read registers carry no reset; only control state is reset.
    always_ff @(posedge clk) begin
      if (init_we) begin
        lane_mem[cnt] <= '0;
      end else begin
        if (b_lwe) lane_mem[b_addr] <= b_wdata[LO +: W];
        if (a_lwe) lane_mem[a_addr] <= a_wdata[LO +: W];
      end
      // Write-first: a reader at the other port's write address sees the new lane data.
      if (a_rd) a_q <= (b_lwe && same_addr) ? b_wdata[LO +: W] : lane_mem[a_addr];
      if (b_rd) b_q <= (a_lwe && same_addr) ? a_wdata[LO +: W] : lane_mem[b_addr];
    end

    assign a_q1[LO +: W] = a_q;
    assign b_q1[LO +: W] = b_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rv1     <= 1'b0;
      b_rv1     <= 1'b0;
      collision <= 1'b0;
    end else begin
      a_rv1     <= a_rd;
      b_rv1     <= b_rd;
      collision <= a_wr & b_wr & same_addr;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic                  a_rv2, b_rv2;
    logic [DATA_WIDTH-1:0] a_d2, b_d2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_rv2 <= 1'b0;
        b_rv2 <= 1'b0;
        a_d2  <= '0;
        b_d2  <= '0;
      end else begin
        a_rv2 <= a_rv1;
        b_rv2 <= b_rv1;
        if (a_rv1) a_d2 <= a_q1;
        if (b_rv1) b_d2 <= b_q1;
      end
    end

    assign a_rvalid = a_rv2;
    assign b_rvalid = b_rv2;
    assign a_rdata  = a_d2;
    assign b_rdata  = b_d2;
  end else begin : g_noreg
    // The unreset read registers are masked to zero until the first read after reset lands.
    logic a_got, b_got;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_got <= 1'b0;
        b_got <= 1'b0;
      end else begin
        a_got <= a_got | a_rd;
        b_got <= b_got | b_rd;
      end
    end

    assign a_rvalid = a_rv1;
    assign b_rvalid = b_rv1;
    assign a_rdata  = a_got ? a_q1 : '0;
    assign b_rdata  = b_got ? b_q1 : '0;
  end

endmodule

// File: tb/tb_dualmem_param.sv
// Drives two dualmem_param instances (latency 1 with zero-fill, latency 2 without) with
// identical stimulus and compares both against a word-level reference model.
module tb_dualmem_param;

  localparam int DW    = 80;
  localparam int AW    = 4;
  localparam int LW    = 36;
  localparam int LN    = 3;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;

  logic [1:0]    req, we;
  logic [LN-1:0] be    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];

  logic [1:0]      busy, coll;
  logic [1:0][1:0] gnt, rv;
  logic [DW-1:0]   rd [2][2];

  // Reference model: memory image per instance, expected held read data, pending latency-2 reads.
  logic [DW-1:0] mm [2][DEPTH];
  logic [DW-1:0] exp_rd [2][2];
  logic [1:0]    pend_v;
  logic [DW-1:0] pend_d [2];
  int            busy_left;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  dualmem_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE_WIDTH(LW), .OUT_REG(0), .INIT_ON_RESET(1)) dut0 (
    .clk(clk), .rst(rst), .init_busy(busy[0]),
    .a_req(req[0]), .a_gnt(gnt[0][0]), .a_we(we[0]), .a_be(be[0]), .a_addr(addr[0]),
    .a_wdata(wdata[0]), .a_rvalid(rv[0][0]), .a_rdata(rd[0][0]),
    .b_req(req[1]), .b_gnt(gnt[0][1]), .b_we(we[1]), .b_be(be[1]), .b_addr(addr[1]),
    .b_wdata(wdata[1]), .b_rvalid(rv[0][1]), .b_rdata(rd[0][1]),
    .collision(coll[0])
  );

  dualmem_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE_WIDTH(LW), .OUT_REG(1), .INIT_ON_RESET(0)) dut1 (
    .clk(clk), .rst(rst), .init_busy(busy[1]),
    .a_req(req[0]), .a_gnt(gnt[1][0]), .a_we(we[0]), .a_be(be[0]), .a_addr(addr[0]),
    .a_wdata(wdata[0]), .a_rvalid(rv[1][0]), .a_rdata(rd[1][0]),
    .b_req(req[1]), .b_gnt(gnt[1][1]), .b_we(we[1]), .b_be(be[1]), .b_addr(addr[1]),
    .b_wdata(wdata[1]), .b_rvalid(rv[1][1]), .b_rdata(rd[1][1]),
    .collision(coll[1])
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] data,
                                          input logic [LN-1:0] lanes);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < DW; b++) if (lanes[b / LW]) r[b] = data[b];
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic drive(input int p, input logic r, input logic w, input logic [LN-1:0] b,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p]   = r;
    we[p]    = w;
    be[p]    = b;
    addr[p]  = a;
    wdata[p] = d;
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // One clock cycle: check combinational outputs, advance the model, then check registered outputs.
  task automatic step();
    logic [1:0]      acc, wr, rdq;
    logic [DW-1:0]   word [2];
    logic [1:0][1:0] erv;
    logic [1:0]      ecoll;
    logic            rdy;
    #1;
    if (rst) pend_v = '0;
    for (int d = 0; d < 2; d++) begin
      rdy = !rst && (d == 1 || busy_left == 0);
      check($sformatf("init_busy%0d", d), DW'(busy[d]),
            DW'((d == 0) ? (rst || busy_left > 0) : 1'b0));
      for (int p = 0; p < 2; p++) begin
        acc[p] = req[p] & rdy;
        wr[p]  = acc[p] & we[p];
        rdq[p] = acc[p] & ~we[p];
        check($sformatf("gnt%0d_%0d", d, p), DW'(gnt[d][p]), DW'(acc[p]));
      end
      for (int p = 0; p < 2; p++) begin
        word[p] = mm[d][addr[p]];
        if (wr[1] && addr[1] == addr[p]) word[p] = merge(word[p], wdata[1], be[1]);
        if (wr[0] && addr[0] == addr[p]) word[p] = merge(word[p], wdata[0], be[0]);
      end
      if (wr[1]) mm[d][addr[1]] = word[1];
      if (wr[0]) mm[d][addr[0]] = word[0];
      ecoll[d] = wr[0] & wr[1] & (addr[0] == addr[1]);
      for (int p = 0; p < 2; p++) begin
        if (d == 0) begin
          erv[d][p] = rdq[p];
          if (rdq[p]) exp_rd[d][p] = word[p];
        end else begin
          erv[d][p] = pend_v[p];
          if (pend_v[p]) exp_rd[d][p] = pend_d[p];
          pend_v[p] = rdq[p];
          pend_d[p] = word[p];
        end
      end
    end
    @(posedge clk);
    #1;
    if (!rst && busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) for (int i = 0; i < DEPTH; i++) mm[0][i] = '0;
    end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("collision%0d", d), DW'(coll[d]), DW'(ecoll[d]));
      for (int p = 0; p < 2; p++) begin
        check($sformatf("rvalid%0d_%0d", d, p), DW'(rv[d][p]), DW'(erv[d][p]));
        check($sformatf("rdata%0d_%0d", d, p), rd[d][p], exp_rd[d][p]);
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle();
    busy_left = DEPTH;
    pend_v = '0;
    for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) exp_rd[d][p] = '0;
    for (int i = 0; i < n; i++) step();
    rst = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) for (int i = 0; i < DEPTH; i++) mm[d][i] = 'x;
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    do_reset(3);

    // Partial fill interrupted by reset, then a full fill with port A requesting reads throughout.
    for (int i = 0; i < 5; i++) step();
    do_reset(2);
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(0, 1'b1, 1'b0, '0, AW'(i), '0);
      step();
    end

    // Every address reads back zero after the fill.
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1'b1, 1'b0, '0, AW'(i), '0);
      drive(1, 1'b1, 1'b0, '0, AW'(DEPTH - 1 - i), '0);
      step();
    end
    idle();
    step();

    // Single low-lane write leaves the other lanes untouched.
    drive(0, 1'b1, 1'b1, 3'b001, 4'd3, 80'h00AA_BBBB_CCCC_DDDD_EEEE);
    step();
    drive(0, 1'b1, 1'b0, '0, 4'd3, '0);
    step();
    idle();
    step();
    step();

    // Full-address fill so both images are fully known.
    for (int i = 0; i < DEPTH / 2; i++) begin
      drive(0, 1'b1, 1'b1, 3'b111, AW'(i), rnd());
      drive(1, 1'b1, 1'b1, 3'b111, AW'(i + DEPTH / 2), rnd());
      step();
    end

    // Write/write collision at address 5: full overlap, then disjoint lanes.
    drive(0, 1'b1, 1'b1, 3'b111, 4'd5, 80'h1111);
    drive(1, 1'b1, 1'b1, 3'b111, 4'd5, 80'h2222);
    step();
    drive(0, 1'b1, 1'b0, '0, 4'd5, '0);
    drive(1, 1'b1, 1'b0, '0, 4'd5, '0);
    step();
    drive(0, 1'b1, 1'b1, 3'b001, 4'd5, rnd());
    drive(1, 1'b1, 1'b1, 3'b110, 4'd5, rnd());
    step();
    drive(0, 1'b1, 1'b0, '0, 4'd5, '0);
    idle();
    drive(0, 1'b1, 1'b0, '0, 4'd5, '0);
    step();

    // Write-first: B reads address 7 while A updates its low lane.
    drive(0, 1'b1, 1'b1, 3'b111, 4'd7, '1);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    step();
    drive(0, 1'b1, 1'b1, 3'b001, 4'd7, 80'h0F0F);
    drive(1, 1'b1, 1'b0, '0, 4'd7, '0);
    step();
    idle();
    step();
    step();

    // Randomised traffic on a narrow address window to force frequent conflicts.
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++)
        drive(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 3'($urandom),
              AW'($urandom_range(0, 3)), rnd());
      step();
    end

    // Back-to-back reads of 0..7, then the same burst cut by reset after the third read.
    idle();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b1, 1'b0, '0, AW'(i), '0);
      step();
    end
    idle();
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 1'b0, '0, AW'(i), '0);
      step();
    end
    do_reset(2);
    for (int i = 0; i < DEPTH + 1; i++) step();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b1, 1'b0, '0, AW'(i), '0);
      drive(1, 1'b1, 1'b0, '0, AW'(i + 8), '0);
      step();
    end
    idle();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
